// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared types and helpers for the dot_acc signed dot-product
// accumulator.
//   state_t   : accumulator FSM states. Only the build without
//               DOT_ACC_SKID_EN uses them.
//   acc_w()   : accumulator/result width for a given operand width and length.
//   RES_CNT_W : width of the delivered-results counter.
package dot_acc_pkg;

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  localparam int RES_CNT_W = 16;

  // Sum of len products of width 2*data_w needs $clog2(len) extra bits.
  function automatic int acc_w(input int data_w, input int len);
    return 2 * data_w + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_acc_out_reg.sv
// dot_acc_out_reg: result register with valid/ready handshake and a
// delivered-results counter.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   load       : capture load_data as a new pending result (from the core)
//   load_data  : finished dot-product sum
//   res_ready  : consumer accepts the result
//   res_valid  : result pending
//   res_data   : pending result, held stable until accepted
//   res_cnt    : results delivered since reset; wraps at 2^RES_CNT_W
// The core only asserts load when the register is empty or being retired in
// the same cycle. A load never overwrites an unaccepted result.
module dot_acc_out_reg
  import dot_acc_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ACC_W-1:0]     load_data,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [ACC_W-1:0]     res_data,
  output logic [RES_CNT_W-1:0] res_cnt
);

  // Result register, valid flag and delivery counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cnt   <= '0;
    end else begin
      // A load in the retire cycle keeps valid high (back-to-back results).
      if (load) begin
        res_valid <= 1'b1;
        res_data  <= load_data;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (res_valid && res_ready) begin
        res_cnt <= res_cnt + RES_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dot_acc.sv
// dot_acc: signed dot-product accumulator. It sums LEN consecutive signed
// products of width 2*DATA_W and presents each sum on a valid/ready output.
// Parameters: DATA_W (operand width), LEN (products per vector, >= 2).
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   prod_valid  : product present
//   prod_ready  : product accepted this cycle (low while rst is high)
//   prod_data   : signed product, 2*DATA_W bits
//   res_valid   : dot-product result present
//   res_ready   : consumer accepts the result
//   res_data    : signed sum of LEN products, ACC_W bits
//   res_cnt     : results delivered since reset (16 bits, wraps)
// Build option: DOT_ACC_SKID_EN. When it is defined, accumulation of the next
// vector overlaps with a pending result. Only the final product of that
// vector stalls. When it is undefined, an S_ACC/S_OUT FSM stalls the input
// for the whole time a result is pending.
module dot_acc
  import dot_acc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int LEN    = 4,
  localparam int ACC_W  = acc_w(DATA_W, LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [2*DATA_W-1:0]  prod_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     res_data,
  output logic [RES_CNT_W-1:0] res_cnt
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(LEN);
  localparam int EXT_W  = ACC_W - PROD_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic             accept_s;
  logic             last_s;
  logic             load_s;

  assign prod_ext_s = {{EXT_W{prod_data[PROD_W-1]}}, prod_data};
  assign sum_s      = acc_r + prod_ext_s;
  assign accept_s   = prod_valid & prod_ready;
  assign last_s     = (cnt_r == CNT_LAST);
  assign load_s     = accept_s & last_s;

  // Partial sum and product counter. Both clear when a vector completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (accept_s) begin
      if (last_s) begin
        acc_r <= '0;
        cnt_r <= '0;
      end else begin
        acc_r <= sum_s;
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

`ifdef DOT_ACC_SKID_EN
  // Stall only the final product, and only while the previous result waits.
  always_comb begin
    prod_ready = 1'b0;
    if (rst) begin
      prod_ready = 1'b0;
    end else begin
      prod_ready = ~(res_valid & ~res_ready & last_s);
    end
  end
`else
  state_t state_r;
  state_t next_state_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_ACC;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and input ready. The input is closed while a result is pending.
  always_comb begin
    next_state_s = state_r;
    prod_ready   = 1'b0;
    case (state_r)
      S_ACC: begin
        prod_ready = ~rst;
        if (load_s) begin
          next_state_s = S_OUT;
        end else begin
          next_state_s = S_ACC;
        end
      end
      S_OUT: begin
        prod_ready = 1'b0;
        if (res_ready) begin
          next_state_s = S_ACC;
        end else begin
          next_state_s = S_OUT;
        end
      end
      default: begin
        next_state_s = S_ACC;
        prod_ready   = 1'b0;
      end
    endcase
  end
`endif

  dot_acc_out_reg #(
    .ACC_W(ACC_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (sum_s),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_cnt   (res_cnt)
  );

endmodule

// File: tb/tb_dot_acc.sv
// Self-checking bench for dot_acc (DATA_W=8, LEN=4). A negedge scoreboard
// groups accepted products into vectors of LEN and checks every delivered
// result, res_cnt, prod_ready and hold stability. Directed table vectors and
// multi-cycle sequences run on top, followed by a randomized phase.
module tb_dot_acc;
  localparam int DATA_W = 8;
  localparam int LEN    = 4;
  localparam int ACC_W  = 18;
`ifdef DOT_ACC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              prod_valid;
  logic              prod_ready;
  logic [15:0]       prod_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [15:0]       res_cnt;

  int checks = 0;
  int passes = 0;

  dot_acc #(.DATA_W(DATA_W), .LEN(LEN)) dut (
    .clk(clk), .rst(rst),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: products grouped into vectors, sums queued for delivery.
  longint     part_q[$];
  longint     exp_q[$];
  int         exp_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [17:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      exp_cnt = 0;
      prev_hold = 1'b0;
      check("rst_prod_ready", prod_ready, 0);
      check("rst_res_valid", res_valid, 0);
    end else begin
      logic exp_rdy;
      if (SKID) exp_rdy = !(res_valid && !res_ready && part_q.size() == LEN - 1);
      else      exp_rdy = !res_valid;
      check("prod_ready", prod_ready, exp_rdy);
      check("res_cnt", res_cnt, exp_cnt % 65536);
      if (prev_hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, prev_data);
      end
      if (res_valid && res_ready) begin
        check("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("res_data", longint'($signed(res_data)), exp_q.pop_front());
        exp_cnt++;
      end
      if (prod_valid && prod_ready) begin
        part_q.push_back(longint'($signed(prod_data)));
        if (part_q.size() == LEN) begin
          exp_q.push_back(part_q.sum());
          part_q.delete();
        end
      end
      prev_hold = res_valid & ~res_ready;
      prev_data = res_data;
    end
  end

  // Present one product until accepted; returns the number of stall cycles.
  task automatic send(input logic [15:0] d, output int waits);
    prod_valid = 1'b1;
    prod_data  = d;
    waits = 0;
    @(negedge clk);
    while (!prod_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    check("send_timeout", waits < 50, 1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] p[LEN];
    longint      exp;
  } vec_t;

  vec_t tab[5];

  initial begin
    int w;
    int acc_n;
    int idx;
    int budget;
    logic [15:0] bp_vals[4];

    rst = 1'b1; prod_valid = 1'b0; prod_data = '0; res_ready = 1'b1;

    tab[0].p = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};            tab[0].exp = 10;
    tab[1].p = '{16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384}; tab[1].exp = 65536;
    tab[2].p = '{-16'sd16384, -16'sd16384, -16'sd16384, -16'sd16384}; tab[2].exp = -65536;
    tab[3].p = '{16'sd100, -16'sd300, 16'sd7, -16'sd7};      tab[3].exp = -200;
    tab[4].p = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};            tab[4].exp = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_data", res_data, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_ready_low", prod_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", prod_ready, 1);

    // Table vectors with res_ready held high.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < LEN; j++) send(tab[i].p[j], w);
      check("tab_valid", res_valid, 1);
      check("tab_data", longint'($signed(res_data)), tab[i].exp);
      if (i == 2) check("tab_neg_raw", res_data, 18'h30000);
      cycle();
      check("tab_cnt", res_cnt, i + 1);
      check("tab_valid_clr", res_valid, 0);
    end

    // Backpressure: first result held for 10 cycles while products stream.
    send(16'd11, w); send(16'd12, w); send(16'd13, w); send(16'd14, w);
    res_ready = 1'b0;
    bp_vals = '{16'd1, 16'd2, 16'd3, 16'd4};
    prod_valid = 1'b1;
    idx = 0; acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      prod_data = bp_vals[idx];
      @(negedge clk);
      check("bp_data", res_data, 50);
      if (prod_ready) begin acc_n++; idx++; end
      cycle();
    end
    check("bp_accepted", acc_n, SKID ? 3 : 0);
    res_ready = 1'b1;
    budget = 0;
    while (idx < 4 && budget < 20) begin
      prod_data = bp_vals[idx];
      @(negedge clk);
      if (prod_ready) idx++;
      budget++;
      cycle();
    end
    prod_valid = 1'b0;
    check("bp_resume", idx, 4);
    repeat (4) cycle();
    check("bp_drained", exp_q.size(), 0);
    check("bp_cnt", res_cnt, 7);

    // Reset with a pending, unaccepted result: it is discarded.
    res_ready = 1'b0;
    for (int j = 0; j < LEN; j++) send(16'd9, w);
    check("pend_valid", res_valid, 1);
    rst = 1'b1; #1;
    check("pend_rst_valid", res_valid, 0);
    check("pend_rst_data", res_data, 0);
    cycle(); rst = 1'b0; res_ready = 1'b1;

    // Reset mid-vector, then a fresh vector.
    send(16'd7, w); send(16'd9, w);
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    check("mid_rst_cnt", res_cnt, 0);
    for (int j = 0; j < LEN; j++) send(16'd5, w);
    check("mid_rst_data", longint'($signed(res_data)), 20);
    cycle();
    check("mid_rst_res_cnt", res_cnt, 1);

    // Back-to-back products 1..8: stall cycles show the dead cycle per vector.
    acc_n = 0;
    for (int j = 1; j <= 8; j++) begin
      send(16'(j), w);
      acc_n += w;
    end
    check("b2b_stalls", acc_n, SKID ? 0 : 1);
    repeat (3) cycle();
    check("b2b_cnt", res_cnt, 3);
    check("b2b_drained", exp_q.size(), 0);

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 800; c++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_data  = 16'($urandom);
      res_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    prod_valid = 1'b0;
    res_ready  = 1'b1;
    repeat (5) cycle();
    check("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
